// File: rtl/axis_frame_arb_if.sv
// AXI4-Stream video link: one pixel per beat, tuser marks start-of-frame,
// tlast marks end-of-line.
//   tdata  : pixel (DATA_WIDTH bits)
//   tvalid : beat valid, driven by the master
//   tready : beat accepted, driven by the slave
//   tuser  : start-of-frame marker
//   tlast  : end-of-line marker
interface axis_frame_arb_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tuser;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/axis_frame_arb.sv
// Frame-granular round-robin arbiter sharing one colour-conversion core
// between two AXI4-Stream video sources. A source is granted only on its
// start-of-frame beat and keeps the grant until the last line of the frame.
//   clk_in, reset     : clock, async active-low reset
//   enable            : allow new grants (sampled in IDLE only)
//   s0, s1            : source streams (slave side)
//   m                 : stream towards the core (master side)
//   grant_id          : source currently / last granted
//   busy              : a frame is being forwarded
//   frame_done        : one-cycle pulse after a frame's last line
//   sof_err           : one-cycle pulse on a mid-frame start-of-frame
//   frame_cnt         : completed frames, wrapping
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | drop pre-SOF fragments, pick the next requester
// ST_ACTIVE | zero-latency pass-through of the granted source
module axis_frame_arb #(
  parameter int DATA_WIDTH      = 24,
  parameter int LINES_PER_FRAME = 1080,
  parameter int LINE_CNT_W      = 12
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        enable,
  axis_frame_arb_if.slave  s0,
  axis_frame_arb_if.slave  s1,
  axis_frame_arb_if.master m,
  output logic        grant_id,
  output logic        busy,
  output logic        frame_done,
  output logic        sof_err,
  output logic [15:0] frame_cnt
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;
  localparam logic [LINE_CNT_W-1:0] LAST_LINE = LINE_CNT_W'(LINES_PER_FRAME - 1);

  logic [0:0]            state_q, state_d;
  logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic                  grant_q, grant_d;
  logic                  first_q, first_d;
  logic                  frame_done_q, frame_done_d;
  logic                  sof_err_q, sof_err_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;

  logic req0, req1;

  assign req0 = s0.tvalid & s0.tuser;
  assign req1 = s1.tvalid & s1.tuser;

  always_comb begin
    state_d      = state_q;
    line_cnt_d   = line_cnt_q;
    grant_d      = grant_q;
    first_d      = first_q;
    frame_done_d = 1'b0;
    sof_err_d    = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    s0.tready    = 1'b0;
    s1.tready    = 1'b0;
    m.tvalid     = 1'b0;
    m.tdata      = '0;
    m.tuser      = 1'b0;
    m.tlast      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Beats before a start-of-frame are accepted and thrown away so a
        // source joining mid-frame cannot stall; SOF beats are held.
        s0.tready = s0.tvalid & ~s0.tuser;
        s1.tready = s1.tvalid & ~s1.tuser;
        if (enable && (req0 || req1)) begin
          state_d    = ST_ACTIVE;
          grant_d    = (req0 && req1) ? ~grant_q : req1;
          line_cnt_d = '0;
          first_d    = 1'b1;
        end
      end

      ST_ACTIVE: begin
        if (grant_q) begin
          m.tdata   = s1.tdata;
          m.tvalid  = s1.tvalid;
          m.tuser   = s1.tuser;
          m.tlast   = s1.tlast;
          s1.tready = m.tready;
        end else begin
          m.tdata   = s0.tdata;
          m.tvalid  = s0.tvalid;
          m.tuser   = s0.tuser;
          m.tlast   = s0.tlast;
          s0.tready = m.tready;
        end

        if (m.tvalid && m.tready) begin
          first_d = 1'b0;
          // A repeated SOF restarts the frame and wins over a coincident
          // frame-closing tlast.
          if (m.tuser && !first_q) begin
            sof_err_d  = 1'b1;
            line_cnt_d = '0;
          end else if (m.tlast) begin
            if (line_cnt_q == LAST_LINE) begin
              frame_done_d = 1'b1;
              frame_cnt_d  = frame_cnt_q + 16'd1;
              line_cnt_d   = '0;
              state_d      = ST_IDLE;
            end else begin
              line_cnt_d = line_cnt_q + 1'b1;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // No handshakes at all while reset is held.
    if (!reset) begin
      s0.tready = 1'b0;
      s1.tready = 1'b0;
      m.tvalid  = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      line_cnt_q   <= '0;
      grant_q      <= 1'b1;
      first_q      <= 1'b0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      line_cnt_q   <= line_cnt_d;
      grant_q      <= grant_d;
      first_q      <= first_d;
      frame_done_q <= frame_done_d;
      sof_err_q    <= sof_err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign grant_id   = grant_q;
  assign busy       = (state_q == ST_ACTIVE);
  assign frame_done = frame_done_q;
  assign sof_err    = sof_err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
